// File: rtl/bht_upd_if.sv
// Resolved-branch update channel into the BHT write sequencer.
// The producer drives valid and payload, and the sequencer returns ready.
interface bht_upd_if #(
  parameter int unsigned INDEX_BITS = 9,
  parameter int unsigned COL_BITS   = 1,
  parameter int unsigned TAG_BITS   = 8
) ();
  logic                  upd_valid;
  logic                  upd_ready;
  logic [INDEX_BITS-1:0] upd_index;
  logic [COL_BITS-1:0]   upd_col;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_taken;

  modport master (
    output upd_valid, upd_index, upd_col, upd_tag, upd_taken,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_index, upd_col, upd_tag, upd_taken,
    output upd_ready
  );
endinterface

// File: rtl/bht_update_ctrl.sv
// BHT write-port sequencer: update FIFO with counter read-modify-write, plus init/flush row sweep.
// Define BHT_UPD_STATS_EN to enable the saturating dropped-update counter on dropped_cnt_o.
module bht_update_ctrl #(
  parameter  int unsigned NR_ROWS         = 512,
  parameter  int unsigned INSTR_PER_FETCH = 2,
  parameter  int unsigned TAG_BITS        = 8,
  parameter  int unsigned UPD_DEPTH       = 4,
  localparam int unsigned INDEX_BITS      = $clog2(NR_ROWS),
  localparam int unsigned COL_BITS        = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic                       rd_conflict_i,
  bht_upd_if.slave                   upd,
  output logic [INDEX_BITS-1:0]      lk_index_o,
  output logic [COL_BITS-1:0]        lk_col_o,
  input  logic [1:0]                 lk_counter_i,
  input  logic [TAG_BITS-1:0]        lk_tag_i,
  output logic                       wr_en_o,
  output logic [INDEX_BITS-1:0]      wr_index_o,
  output logic [INSTR_PER_FETCH-1:0] wr_col_mask_o,
  output logic [1:0]                 wr_counter_o,
  output logic                       wr_tag_en_o,
  output logic [TAG_BITS-1:0]        wr_tag_o,
  output logic                       busy_o,
  output logic [15:0]                dropped_cnt_o
);

  localparam int unsigned PTR_BITS = $clog2(UPD_DEPTH);
  localparam logic [INDEX_BITS-1:0] LAST_ROW = INDEX_BITS'(NR_ROWS - 1);

  typedef enum logic [1:0] {INIT_SWEEP, IDLE, FLUSH_SWEEP} state_e;

  typedef struct packed {
    logic [INDEX_BITS-1:0] index;
    logic [COL_BITS-1:0]   col;
    logic [TAG_BITS-1:0]   tag;
    logic                  taken;
  } upd_t;

  function automatic logic [1:0] next_counter(input logic [1:0] cnt, input logic tag_hit,
                                              input logic taken);
    logic [1:0] res;
    if (!tag_hit)        res = taken ? 2'b10 : 2'b01;
    else if (taken)      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    else                 res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    return res;
  endfunction

  function automatic logic [INSTR_PER_FETCH-1:0] col_mask(input logic [COL_BITS-1:0] col);
    return INSTR_PER_FETCH'(1) << col;
  endfunction

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   row_q, row_d;
  upd_t                    fifo_q [UPD_DEPTH];
  logic [PTR_BITS:0]       wr_ptr_q, rd_ptr_q;
  upd_t                    head, upd_in;
  logic                    empty, full, busy, push, pop, wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                 (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
  assign busy  = (state_q != IDLE);
  assign head  = fifo_q[rd_ptr_q[PTR_BITS-1:0]];

  assign upd_in        = '{index: upd.upd_index, col: upd.upd_col,
                           tag: upd.upd_tag, taken: upd.upd_taken};
  assign upd.upd_ready = ~full & ~busy;
  assign push          = upd.upd_valid & upd.upd_ready & ~debug_mode_i & ~flush_i;

  assign busy_o     = busy;
  assign lk_index_o = head.index;
  assign lk_col_o   = head.col;
  // Reset forces the strobe low even though the state already sits in INIT_SWEEP.
  assign wr_en_o    = wr_en & rst_ni;

  // FIFO storage: payload only, no reset needed
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q[PTR_BITS-1:0]] <= upd_in;
  end

  // FIFO pointers: flush discards everything queued
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT_SWEEP;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next state and write-port outputs
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    wr_en         = 1'b0;
    pop           = 1'b0;
    wr_index_o    = row_q;
    wr_col_mask_o = '1;
    wr_counter_o  = 2'b10;
    wr_tag_en_o   = 1'b0;
    wr_tag_o      = head.tag;
    case (state_q)
      INIT_SWEEP, FLUSH_SWEEP: begin
        if (!rd_conflict_i) begin
          wr_en = 1'b1;
          if (row_q == LAST_ROW) begin
            state_d = IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      IDLE: begin
        wr_index_o    = head.index;
        wr_col_mask_o = col_mask(head.col);
        wr_counter_o  = next_counter(lk_counter_i, lk_tag_i == head.tag, head.taken);
        wr_tag_en_o   = 1'b1;
        if (!empty && !rd_conflict_i) begin
          wr_en = 1'b1;
          pop   = 1'b1;
        end
      end
      default: state_d = INIT_SWEEP;
    endcase
    if (flush_i) begin
      state_d = FLUSH_SWEEP;
      row_d   = '0;
    end
  end

`ifdef BHT_UPD_STATS_EN
  logic        drop;
  logic [15:0] dropped_q;

  assign drop = upd.upd_valid & (busy | debug_mode_i | flush_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            dropped_q <= '0;
    else if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
  end

  assign dropped_cnt_o = dropped_q;
`else
  assign dropped_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Scoreboard bench for bht_update_ctrl: stimulus queues expected writes, a negedge monitor checks them.
module tb_bht_update_ctrl;
`ifdef BHT_UPD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni, flush, debug, rd_conflict;
  logic [8:0]  lk_index, wr_index;
  logic [0:0]  lk_col;
  logic [1:0]  lk_counter, wr_mask, wr_counter;
  logic [7:0]  lk_tag, wr_tag;
  logic        wr_en, wr_tag_en, busy;
  logic [15:0] dropped;

  bht_upd_if #(.INDEX_BITS(9), .COL_BITS(1), .TAG_BITS(8)) upd_if ();

  bht_update_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .debug_mode_i(debug),
    .rd_conflict_i(rd_conflict), .upd(upd_if),
    .lk_index_o(lk_index), .lk_col_o(lk_col), .lk_counter_i(lk_counter), .lk_tag_i(lk_tag),
    .wr_en_o(wr_en), .wr_index_o(wr_index), .wr_col_mask_o(wr_mask),
    .wr_counter_o(wr_counter), .wr_tag_en_o(wr_tag_en), .wr_tag_o(wr_tag),
    .busy_o(busy), .dropped_cnt_o(dropped)
  );

  // Table emulation: registered storage, combinational lookup
  logic [1:0] cnt_tbl [512][2];
  logic [7:0] tag_tbl [512][2];
  logic       poke_en;
  logic [8:0] poke_idx;
  logic       poke_col;
  logic [1:0] poke_cnt;
  logic [7:0] poke_tag;

  assign lk_counter = cnt_tbl[lk_index][lk_col];
  assign lk_tag     = tag_tbl[lk_index][lk_col];

  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int r = 0; r < 512; r++)
        for (int c = 0; c < 2; c++) begin
          cnt_tbl[r][c] <= 2'b00;
          tag_tbl[r][c] <= 8'h00;
        end
    end else begin
      if (wr_en)
        for (int c = 0; c < 2; c++)
          if (wr_mask[c]) begin
            cnt_tbl[wr_index][c] <= wr_counter;
            if (wr_tag_en) tag_tbl[wr_index][c] <= wr_tag;
          end
      if (poke_en) begin
        cnt_tbl[poke_idx][poke_col] <= poke_cnt;
        tag_tbl[poke_idx][poke_col] <= poke_tag;
      end
    end
  end

  typedef struct packed {
    logic [8:0] idx;
    logic [1:0] mask;
    logic [1:0] cnt;
    logic       tag_en;
    logic [7:0] tag;
  } wr_t;

  wr_t exp_q [$];
  int  tests = 0;
  int  fails = 0;
  int  wr_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [8:0] idx, input logic [1:0] mask, input logic [1:0] cnt,
                        input logic te, input logic [7:0] tag);
    wr_t e;
    e = '{idx: idx, mask: mask, cnt: cnt, tag_en: te, tag: tag};
    exp_q.push_back(e);
  endtask

  task automatic exp_sweep(input int n);
    for (int r = 0; r < n; r++) exp_wr(9'(r), 2'b11, 2'b10, 1'b0, 8'h00);
  endtask

  // Monitor: every observed write is checked against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_ni && wr_en) begin
      wr_t e, a;
      wr_count++;
      a = '{idx: wr_index, mask: wr_mask, cnt: wr_counter, tag_en: wr_tag_en,
            tag: wr_tag_en ? wr_tag : 8'h00};
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got row %0d mask %b cnt %b, expected no write",
                 wr_index, wr_mask, wr_counter);
      end else begin
        e = exp_q.pop_front();
        chk("write", 32'(a), 32'(e));
      end
    end
  end

  task automatic poke(input logic [8:0] idx, input logic col, input logic [7:0] tag,
                      input logic [1:0] cnt);
    poke_en = 1'b1; poke_idx = idx; poke_col = col; poke_tag = tag; poke_cnt = cnt;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic push(input logic [8:0] idx, input logic col, input logic [7:0] tag,
                      input logic taken);
    upd_if.upd_valid = 1'b1; upd_if.upd_index = idx; upd_if.upd_col = col;
    upd_if.upd_tag = tag; upd_if.upd_taken = taken;
    @(posedge clk); #1;
    upd_if.upd_valid = 1'b0;
  endtask

  // Preload entry, push one update, expect the write exactly one cycle later
  task automatic upd_case(input logic [8:0] idx, input logic col, input logic [7:0] ptag,
                          input logic [1:0] pcnt, input logic [7:0] tag, input logic taken,
                          input logic [1:0] ecnt);
    poke(idx, col, ptag, pcnt);
    exp_wr(idx, col ? 2'b10 : 2'b01, ecnt, 1'b1, tag);
    push(idx, col, tag, taken);
    @(negedge clk);
    chk("min_latency_write", 32'(wr_en), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < max);
    chk({name, "_busy_fell"}, 32'(busy), 32'd0);
  endtask

  int base;

  initial begin
    rst_ni = 1'b0; flush = 1'b0; debug = 1'b0; rd_conflict = 1'b0; poke_en = 1'b0;
    poke_idx = '0; poke_col = 1'b0; poke_cnt = '0; poke_tag = '0;
    upd_if.upd_valid = 1'b0; upd_if.upd_index = '0; upd_if.upd_col = '0;
    upd_if.upd_tag = '0; upd_if.upd_taken = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_ready", 32'(upd_if.upd_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_dropped", 32'(dropped), 32'd0);

    // Init sweep after reset release
    exp_sweep(512);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    wait_idle("init_sweep", 600);
    chk("init_sweep_writes", 32'(wr_count), 32'd512);
    chk("ready_after_sweep", 32'(upd_if.upd_ready), 32'd1);
    chk("init_sweep_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Counter read-modify-write cases
    upd_case(9'd5,  1'b1, 8'h3C, 2'b11, 8'h3C, 1'b0, 2'b10);
    upd_case(9'd7,  1'b0, 8'h11, 2'b11, 8'h22, 1'b1, 2'b10);
    upd_case(9'd8,  1'b0, 8'h11, 2'b00, 8'h22, 1'b0, 2'b01);
    upd_case(9'd9,  1'b1, 8'hAA, 2'b11, 8'hAA, 1'b1, 2'b11);
    upd_case(9'd10, 1'b0, 8'hAA, 2'b00, 8'hAA, 1'b0, 2'b00);
    upd_case(9'd11, 1'b1, 8'h05, 2'b01, 8'h05, 1'b1, 2'b10);
    upd_case(9'd13, 1'b0, 8'h05, 2'b10, 8'h05, 1'b0, 2'b01);

    // Back-to-back to the same entry: second sees the first's result
    exp_wr(9'd12, 2'b01, 2'b10, 1'b1, 8'h07);
    exp_wr(9'd12, 2'b01, 2'b11, 1'b1, 8'h07);
    push(9'd12, 1'b0, 8'h07, 1'b1);
    push(9'd12, 1'b0, 8'h07, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

    // Read conflict fills the FIFO, release drains in order on consecutive cycles
    rd_conflict = 1'b1;
    exp_wr(9'd20, 2'b01, 2'b11, 1'b1, 8'h00);
    exp_wr(9'd21, 2'b10, 2'b11, 1'b1, 8'h00);
    exp_wr(9'd22, 2'b01, 2'b01, 1'b1, 8'h00);
    exp_wr(9'd23, 2'b10, 2'b10, 1'b1, 8'h09);
    push(9'd20, 1'b0, 8'h00, 1'b1);
    push(9'd21, 1'b1, 8'h00, 1'b1);
    push(9'd22, 1'b0, 8'h00, 1'b0);
    push(9'd23, 1'b1, 8'h09, 1'b1);
    @(negedge clk);
    chk("full_ready_low", 32'(upd_if.upd_ready), 32'd0);
    chk("conflict_no_write", 32'(wr_en), 32'd0);
    @(posedge clk); #1;
    rd_conflict = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_consecutive", 32'(wr_en), 32'd1);
    end
    @(negedge clk);
    chk("drain_done", 32'(wr_en), 32'd0);
    @(posedge clk); #1;

    // Debug mode discards offered updates
    debug = 1'b1;
    push(9'd30, 1'b0, 8'h01, 1'b1);
    push(9'd31, 1'b1, 8'h02, 1'b1);
    push(9'd32, 1'b0, 8'h03, 1'b0);
    debug = 1'b0;
    @(negedge clk);
    chk("dropped_debug", 32'(dropped), STATS ? 32'd3 : 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("debug_no_write", 32'(wr_en), 32'd0);
    end
    @(posedge clk); #1;

    // Flush sweep, then re-flush with row 200 pending restarts at row 0
    exp_sweep(200);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    exp_sweep(512);
    rd_conflict = 1'b1; flush = 1'b1;
    upd_if.upd_valid = 1'b1; upd_if.upd_index = 9'd40; upd_if.upd_col = 1'b0;
    upd_if.upd_tag = 8'h44; upd_if.upd_taken = 1'b1;
    @(negedge clk);
    chk("flush_stall_no_write", 32'(wr_en), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    base = wr_count;
    @(posedge clk); #1;
    rd_conflict = 1'b0; flush = 1'b0; upd_if.upd_valid = 1'b0;
    @(negedge clk);
    chk("dropped_flush", 32'(dropped), STATS ? 32'd4 : 32'd0);
    wait_idle("flush_sweep", 600);
    chk("flush_sweep_writes", 32'(wr_count - base), 32'd512);
    chk("ready_after_flush", 32'(upd_if.upd_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end
endmodule
